// File: rtl/line_memory_pkg.sv
// Shared types and helpers for the line memory: FSM states and
// byte-address to line-index mapping.
package line_memory_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    ACK  = 2'd2
  } state_e;

  localparam int LINE_OFFSET_BITS = 5;

  // Returns the line index zero-extended to 32 bits; callers truncate to DEPTH_LOG2.
  function automatic logic [31:0] line_index(input logic [31:0] addr,
                                             input int unsigned depth_log2);
    return (addr >> LINE_OFFSET_BITS) & ((32'd1 << depth_log2) - 32'd1);
  endfunction

endpackage

// File: rtl/line_memory_if.sv
// Request/response bus between the dcache controller (master) and the
// line memory (slave).
interface line_memory_if #(
  parameter int LINE_W = 256
) ();

  logic              enable;
  logic              write;
  logic [31:0]       addr;
  logic [LINE_W-1:0] wdata;
  logic              ack;
  logic [LINE_W-1:0] rdata;

  modport master (
    output enable, write, addr, wdata,
    input  ack, rdata
  );

  modport slave (
    input  enable, write, addr, wdata,
    output ack, rdata
  );

endinterface

// File: rtl/line_ram.sv
// Single-port line array: synchronous write, registered read whose output
// holds until the next read. Contents are never reset.
module line_ram #(
  parameter int LINE_W     = 256,
  parameter int DEPTH_LOG2 = 9
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  en_i,
  input  logic                  we_i,
  input  logic [DEPTH_LOG2-1:0] addr_i,
  input  logic [LINE_W-1:0]     wdata_i,
  output logic [LINE_W-1:0]     rdata_o
);

  logic [LINE_W-1:0] mem_q [2**DEPTH_LOG2];
  logic [LINE_W-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (en_i && we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rdata_q <= '0;
    end else if (en_i && !we_i) begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/line_memory.sv
// DRAM-like line memory behind the dcache: one request at a time, answered
// after LATENCY cycles with a single-cycle ack.
module line_memory
  import line_memory_pkg::*;
#(
  parameter int LINE_W     = 256,
  parameter int DEPTH_LOG2 = 9,
  parameter int LATENCY    = 10
) (
  input  logic         clk_i,
  input  logic         rst_i,
  line_memory_if.slave mem
);

  localparam int CNT_W = 8;

  state_e                state_q;
  logic [CNT_W-1:0]      cnt_q;
  logic                  ack_q;
  logic                  we_q;
  logic [DEPTH_LOG2-1:0] idx_q;
  logic [LINE_W-1:0]     wdata_q;

  logic                  ram_en;
  logic [DEPTH_LOG2-1:0] idx_d;
  logic [LINE_W-1:0]     ram_rdata;

  assign idx_d = DEPTH_LOG2'(line_index(mem.addr, DEPTH_LOG2));

  // The array is touched only on the BUSY->ACK edge, using the latched request.
  assign ram_en = (state_q == BUSY) && (cnt_q == '0);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ack_q   <= 1'b0;
      we_q    <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          ack_q <= 1'b0;
          if (mem.enable) begin
            we_q    <= mem.write;
            idx_q   <= idx_d;
            wdata_q <= mem.wdata;
            cnt_q   <= CNT_W'(LATENCY - 1);
            state_q <= BUSY;
          end
        end
        BUSY: begin
          if (cnt_q == '0) begin
            ack_q   <= 1'b1;
            state_q <= ACK;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        ACK: begin
          ack_q   <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          ack_q   <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  line_ram #(
    .LINE_W     (LINE_W),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_ram (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .en_i    (ram_en),
    .we_i    (we_q),
    .addr_i  (idx_q),
    .wdata_i (wdata_q),
    .rdata_o (ram_rdata)
  );

  assign mem.ack   = ack_q;
  assign mem.rdata = ram_rdata;

endmodule

// File: doc/line_memory.md
Name: line_memory

Overview:
- Off-chip backing store for the data cache: 256-bit line memory behind the CPU's external memory port (MemAddr/MemData/MemEnable/MemWrite/MemAck).
- Sits directly downstream of the dcache controller.
- Accepts one line read or line write at a time and answers each after a fixed, parameterised latency with a one-cycle ack pulse.
- Models DRAM timing so cache miss and write-back stalls are exercised at system level.

Parameters:
- LINE_W, 256: line width in bits; must equal the cache line width.
- DEPTH_LOG2, 9: log2 of the number of lines (default 512 lines = 16 KiB).
- LATENCY, 10: cycles from request acceptance to ack; legal range 1..255.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous, active-high reset.
- enable_i  in  1  request valid; held high by the requester until it sees ack_o.
- write_i  in  1  1 = line write, 0 = line read; sampled with enable_i.
- addr_i  in  32  byte address; bits [4:0] ignored (line aligned).
- data_i  in  LINE_W  write line data; sampled with enable_i.
- ack_o  out  1  one-cycle completion pulse.
- data_o  out  LINE_W  read line data; valid while ack_o=1 for a read.

Behaviour:
- Reset is asynchronous: state=IDLE, ack_o=0, data_o=0, counter=0, latched request cleared.
  - Array contents are not reset; the testbench preloads them.
- Line index = addr_i[DEPTH_LOG2+4:5]. Upper address bits are ignored, so addresses alias modulo 2^(DEPTH_LOG2+5).
- States IDLE, BUSY, ACK:
  - IDLE: at an edge with enable_i=1, latch addr/write/data, load counter=LATENCY-1, go to BUSY. With enable_i=0, stay in IDLE.
  - BUSY: ignores all inputs, including enable_i dropping or changing. At each edge, if counter==0 go to ACK, else decrement.
  - ACK: ack_o=1 for exactly this one cycle, then unconditionally back to IDLE.
- Latency: request accepted at edge N → ack_o high between edges N+LATENCY and N+LATENCY+1.
- Array access happens on the BUSY→ACK edge:
  - Write: array[idx] <= latched data; data_o unchanged.
  - Read: data_o <= array[idx]; data_o then holds that value until the next read completes.
- A request sampled in the ACK cycle is not accepted. The next acceptance can occur at the ACK→IDLE edge+1 at the earliest, so there is at least one IDLE cycle between transactions.
  - The requester must drop enable_i in the cycle after ack_o. If enable_i is still high in IDLE, it is a new request.
- Read-after-write to the same line returns the written data, because the write is committed before the following request is accepted.
- Reset asserted in BUSY or ACK aborts the transaction: no array write, ack_o falls immediately.
- Only one outstanding request is supported; there is no queuing.
- Latched data and address are stable through BUSY regardless of input toggling.

Decomposition:
- Shared memory package:
  - state enum {IDLE, BUSY, ACK}.
  - Constant LINE_OFFSET_BITS=5.
  - Function line_index(addr).
- Sub-module line_ram: single-port array with synchronous write and registered read, one access per cycle, no reset of contents.
- line_memory holds the FSM, latency counter and request latches, and instantiates line_ram.

Test Plan:
1. Read after preload (LATENCY=10): preload line 3 = 256'hA5…A5. Pulse a request with enable_i=1, write_i=0, addr_i=32'h60. → ack_o goes high exactly 10 cycles after acceptance, for 1 cycle, with data_o=A5…A5. No ack in any other cycle.
2. Write then read: write addr 32'h0000_0100 with data {8{32'hDEADBEEF}}, wait for ack, then read the same address. → The second ack returns {8{32'hDEADBEEF}}, and data_o is unchanged during the write ack.
3. Aliasing: write addr 32'h0000_4020 (index 1), then read addr 32'h20. → Returns the written line.
4. Input instability: after acceptance, toggle enable_i, write_i, addr_i and data_i every cycle during BUSY. → Exactly one ack, at the original latency, carrying the original latched operation and address.
5. Reset mid-transaction: accept a write to line 5, then assert rst_i 4 cycles later. → ack_o is never seen, line 5 keeps its preload, state is IDLE, and a new read after reset completes normally.
6. LATENCY=1 back-to-back: hold enable_i high continuously. → Acks recur every 3 cycles (accept, BUSY, ACK, IDLE gap). Each ack corresponds to exactly one accepted request.
